// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - host byte feeder for the control block's programming mode
// Optional: define PROG_CHECKSUM_EN to accumulate a mod-2^DATA_W sum of consumed bytes.
module prog_loader #(
    parameter int MEM_DEPTH = 16,
    parameter int DATA_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       prog_start,
    input  logic [DATA_W-1:0]          ui_in,
    input  logic                       byte_valid,
    output logic                       byte_ack,
    input  logic                       ready,
    input  logic                       read_ui_in,
    input  logic                       done_load,
    input  logic                       HF,
    output logic                       programming,
    output logic [DATA_W-1:0]          bus_out,
    output logic                       bus_en,
    output logic [$clog2(MEM_DEPTH):0] load_count,
    output logic                       prog_done,
    output logic                       err_underrun,
    output logic                       err_halt,
    output logic [DATA_W-1:0]          checksum
);

    localparam int CNT_W = $clog2(MEM_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_LOAD,
        S_DRAIN
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                full;
    logic [DATA_W-1:0]   byte_buf;
    logic                session_start;
    logic                abort;
    logic                consume;
    logic                capture;
    logic                finish;

    // Session sequencing; programming only changes on the T0 edge (ready) or on abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the combinational bus and mode outputs.
    always_comb begin
        state_nxt     = state;
        programming   = (state == S_LOAD) || (state == S_DRAIN);
        bus_en        = read_ui_in && (state == S_LOAD);
        bus_out       = full ? byte_buf : '0;
        session_start = (state == S_IDLE) && prog_start;
        abort         = HF && (state != S_IDLE);
        consume       = bus_en && !abort;
        // A consume in the same cycle blocks capture so the host byte is acked later.
        capture       = !full && byte_valid && !bus_en && !abort &&
                        ((state == S_ARM) || (state == S_LOAD));
        finish        = (state == S_DRAIN) && ready && !HF;
        case (state)
            S_IDLE:  if (prog_start) state_nxt = S_ARM;
            S_ARM:   if (HF) state_nxt = S_IDLE;
                     else if (ready) state_nxt = S_LOAD;
            S_LOAD:  if (HF) state_nxt = S_IDLE;
                     else if (done_load && (load_count == CNT_LAST)) state_nxt = S_DRAIN;
            S_DRAIN: if (HF) state_nxt = S_IDLE;
                     else if (ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte buffer, load counter and session status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            full         <= 1'b0;
            byte_buf     <= '0;
            byte_ack     <= 1'b0;
            load_count   <= '0;
            prog_done    <= 1'b0;
            err_underrun <= 1'b0;
            err_halt     <= 1'b0;
        end else begin
            byte_ack <= capture;
            if (session_start) begin
                full         <= 1'b0;
                load_count   <= '0;
                prog_done    <= 1'b0;
                err_underrun <= 1'b0;
                err_halt     <= 1'b0;
            end else if (abort) begin
                full     <= 1'b0;
                err_halt <= 1'b1;
            end else begin
                if (consume) begin
                    full <= 1'b0;
                    if (!full) begin
                        err_underrun <= 1'b1;
                    end
                end
                if (capture) begin
                    full     <= 1'b1;
                    byte_buf <= ui_in;
                end
                if ((state == S_LOAD) && done_load) begin
                    load_count <= load_count + CNT_ONE;
                end
                if (finish) begin
                    prog_done <= 1'b1;
                end
            end
        end
    end

`ifdef PROG_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    // Running sum of every byte handed to the bus, underrun zeros included.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (session_start) begin
            checksum_q <= '0;
        end else if (consume) begin
            checksum_q <= checksum_q + bus_out;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    localparam int MEM_DEPTH = 16;
    localparam int DATA_W    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              prog_start;
    logic [DATA_W-1:0] ui_in;
    logic              byte_valid;
    logic              byte_ack;
    logic              ready;
    logic              read_ui_in;
    logic              done_load;
    logic              HF;
    logic              programming;
    logic [DATA_W-1:0] bus_out;
    logic              bus_en;
    logic [4:0]        load_count;
    logic              prog_done;
    logic              err_underrun;
    logic              err_halt;
    logic [DATA_W-1:0] checksum;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rec_q[$];
    logic [7:0] exp_q[$];
    logic       last_p1;

    always #5 clk = ~clk;

    prog_loader #(.MEM_DEPTH(MEM_DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .prog_start(prog_start), .ui_in(ui_in),
        .byte_valid(byte_valid), .byte_ack(byte_ack), .ready(ready),
        .read_ui_in(read_ui_in), .done_load(done_load), .HF(HF),
        .programming(programming), .bus_out(bus_out), .bus_en(bus_en),
        .load_count(load_count), .prog_done(prog_done),
        .err_underrun(err_underrun), .err_halt(err_halt), .checksum(checksum)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 6-clock instruction cycle of the control block: T0 ready, T3 read, T4 RAM write.
    task automatic instr_cycle(input bit send, input logic [7:0] val);
        ready = 1'b1; read_ui_in = 1'b0; done_load = 1'b0; byte_valid = 1'b0;
        tick();
        ready = 1'b0;
        last_p1 = programming;
        if (send) begin
            byte_valid = 1'b1;
            ui_in = val;
        end
        tick();
        if (send) check("ack_t2", {31'd0, byte_ack}, 32'd1);
        byte_valid = 1'b0;
        tick();
        read_ui_in = programming;
        #1;
        if (bus_en) rec_q.push_back(bus_out);
        tick();
        read_ui_in = 1'b0;
        done_load = programming;
        check("prog_stable", {31'd0, programming}, {31'd0, last_p1});
        tick();
        done_load = 1'b0;
        tick();
    endtask

    task automatic start_session();
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        check("arm_prog", {31'd0, programming}, 32'd0);
        check("start_cnt", {27'd0, load_count}, 32'd0);
        check("start_halt", {31'd0, err_halt}, 32'd0);
    endtask

    task automatic run_session(input logic [7:0] base, input int skip, input int ncyc);
        logic [7:0] v;
        rec_q.delete();
        exp_q.delete();
        for (int i = 0; i < ncyc; i++) begin
            v = base + 8'(i);
            instr_cycle(i != skip, v);
            exp_q.push_back((i == skip) ? 8'h00 : v);
            if (i == 0) check("prog_rise", {31'd0, last_p1}, 32'd1);
        end
    endtask

    task automatic verify_bytes(input string tag);
        logic [7:0] sum;
        sum = 8'h00;
        check({tag, "_nbytes"}, rec_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'd0, rec_q[i]}, {24'd0, exp_q[i]});
        end
        for (int i = 0; i < exp_q.size(); i++) sum = sum + exp_q[i];
`ifdef PROG_CHECKSUM_EN
        check({tag, "_csum"}, {24'd0, checksum}, {24'd0, sum});
`else
        check({tag, "_csum"}, {24'd0, checksum}, 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b1; prog_start = 1'b1; byte_valid = 1'b1; ui_in = 8'hA5;
        ready = 1'b0; read_ui_in = 1'b1; done_load = 1'b0; HF = 1'b0;
        repeat (3) tick();
        check("rst_prog", {31'd0, programming}, 32'd0);
        check("rst_bus_en", {31'd0, bus_en}, 32'd0);
        check("rst_bus_out", {24'd0, bus_out}, 32'd0);
        check("rst_ack", {31'd0, byte_ack}, 32'd0);
        check("rst_cnt", {27'd0, load_count}, 32'd0);
        check("rst_done", {31'd0, prog_done}, 32'd0);
        check("rst_under", {31'd0, err_underrun}, 32'd0);
        check("rst_halt", {31'd0, err_halt}, 32'd0);
        check("rst_csum", {24'd0, checksum}, 32'd0);
        reset = 1'b0; prog_start = 1'b0; read_ui_in = 1'b0;
        tick();
        check("idle_noack", {31'd0, byte_ack}, 32'd0);
        check("idle_prog", {31'd0, programming}, 32'd0);
        byte_valid = 1'b0;

        // Normal session.
        start_session();
        run_session(8'h10, -1, MEM_DEPTH);
        check("norm_cnt", {27'd0, load_count}, 32'd16);
        check("norm_drain_prog", {31'd0, programming}, 32'd1);
        check("norm_drain_done", {31'd0, prog_done}, 32'd0);
        verify_bytes("norm");
        instr_cycle(1'b0, 8'h00);
        check("norm_end_prog", {31'd0, programming}, 32'd0);
        check("norm_done", {31'd0, prog_done}, 32'd1);
        check("norm_under", {31'd0, err_underrun}, 32'd0);

        // Host withholds the third byte.
        start_session();
        check("restart_done", {31'd0, prog_done}, 32'd0);
        run_session(8'h20, 2, MEM_DEPTH);
        check("under_flag", {31'd0, err_underrun}, 32'd1);
        check("under_cnt", {27'd0, load_count}, 32'd16);
        verify_bytes("under");
        instr_cycle(1'b0, 8'h00);
        check("under_done", {31'd0, prog_done}, 32'd1);

        // Back-to-back bytes without a read.
        start_session();
        check("b2b_under_clr", {31'd0, err_underrun}, 32'd0);
        byte_valid = 1'b1; ui_in = 8'hAA;
        tick();
        check("b2b_ack1", {31'd0, byte_ack}, 32'd1);
        ui_in = 8'hBB;
        tick();
        check("b2b_noack2", {31'd0, byte_ack}, 32'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("b2b_noack3", {31'd0, byte_ack}, 32'd0);
        check("b2b_prog", {31'd0, programming}, 32'd1);
        read_ui_in = 1'b1;
        #1;
        check("b2b_bus_en", {31'd0, bus_en}, 32'd1);
        check("b2b_first", {24'd0, bus_out}, 32'hAA);
        tick();
        check("b2b_consume_noack", {31'd0, byte_ack}, 32'd0);
        read_ui_in = 1'b0;
        tick();
        check("b2b_ack_after", {31'd0, byte_ack}, 32'd1);
        byte_valid = 1'b0;
        read_ui_in = 1'b1;
        #1;
        check("b2b_second", {24'd0, bus_out}, 32'hBB);
        tick();
        read_ui_in = 1'b0;
        check("b2b_under", {31'd0, err_underrun}, 32'd0);
        HF = 1'b1;
        tick();
        HF = 1'b0;

        // Halt after five loads.
        start_session();
        run_session(8'h30, -1, 5);
        check("hf_pre_cnt", {27'd0, load_count}, 32'd5);
        check("hf_pre_prog", {31'd0, programming}, 32'd1);
        HF = 1'b1;
        tick();
        HF = 1'b0;
        check("hf_prog", {31'd0, programming}, 32'd0);
        check("hf_flag", {31'd0, err_halt}, 32'd1);
        check("hf_done", {31'd0, prog_done}, 32'd0);
        check("hf_cnt", {27'd0, load_count}, 32'd5);
        byte_valid = 1'b1; ui_in = 8'h55;
        tick();
        check("hf_idle_noack", {31'd0, byte_ack}, 32'd0);
        byte_valid = 1'b0;

        // Reset while draining.
        start_session();
        run_session(8'h40, -1, MEM_DEPTH);
        check("drain_prog", {31'd0, programming}, 32'd1);
        reset = 1'b1;
        tick();
        check("drain_rst_prog", {31'd0, programming}, 32'd0);
        check("drain_rst_done", {31'd0, prog_done}, 32'd0);
        check("drain_rst_cnt", {27'd0, load_count}, 32'd0);
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
